// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage hazard detection and stall sequencing.
// Detects load-use, flag-to-branch, and branch-register dependencies.
// A multi-cycle data stall is issued as one held window by a small
// counter FSM. A memory-busy freeze holds every stage, without a bubble,
// until memory is ready.
// Optional feature: define HAZARD_PERF_EN to build the 16-bit saturating
// performance counters. Without it, the counter ports are tied to zero.
module hazard_stall_ctrl #(
  parameter int          REG_AW        = 4,
  parameter int          OPC_W         = 4,
  parameter int          FLAG_W        = 3,
  parameter logic [OPC_W-1:0] B_OPC    = 4'b1100,
  parameter logic [OPC_W-1:0] BR_OPC   = 4'b1101,
  parameter int          ZERO_REG_EXCL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  ifid_opcode,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_regwrite,
  input  logic              idex_memread,
  input  logic [FLAG_W-1:0] idex_flag_en,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_regwrite,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_write_en,
  output logic              ifid_write_en,
  output logic              idex_write_en,
  output logic              exmem_write_en,
  output logic              ctrl_mux,
  output logic              ifid_flush,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       mem_stall_cycles,
  output logic [15:0]       flush_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    MSTALL = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  state_t     saved_reg, saved_next;
  logic [1:0] cnt_reg, cnt_next;

  logic idex_rd_ok, exmem_rd_ok;
  logic is_b, is_br;
  logic haz_lu, haz_fb, haz_brx, haz_brm;
  logic [1:0] req_len;

  // Hazard terms and the required stall length (longest active term wins).
  always_comb begin
    idex_rd_ok  = (ZERO_REG_EXCL == 0) || (idex_rd != '0);
    exmem_rd_ok = (ZERO_REG_EXCL == 0) || (exmem_rd != '0);
    is_b        = (ifid_opcode == B_OPC);
    is_br       = (ifid_opcode == BR_OPC);
    haz_lu      = idex_memread & idex_regwrite & idex_rd_ok &
                  ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));
    haz_fb      = (is_b | is_br) & (|idex_flag_en);
    haz_brx     = is_br & idex_regwrite & idex_rd_ok & (idex_rd == ifid_rs);
    haz_brm     = is_br & exmem_regwrite & exmem_rd_ok & (exmem_rd == ifid_rs);
    if (haz_brx)
      req_len = 2'd2;
    else if (haz_lu | haz_fb | haz_brm)
      req_len = 2'd1;
    else
      req_len = 2'd0;
  end

  // State, saved-state and stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
      saved_reg <= RUN;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      saved_reg <= saved_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and stage-enable decode; reset forces every output low.
  always_comb begin
    state_next     = state_reg;
    saved_next     = saved_reg;
    cnt_next       = cnt_reg;
    pc_write_en    = 1'b0;
    ifid_write_en  = 1'b0;
    idex_write_en  = 1'b0;
    exmem_write_en = 1'b0;
    ctrl_mux       = 1'b0;
    ifid_flush     = 1'b0;
    case (state_reg)
      RUN: begin
        if (mem_busy) begin
          // Memory not ready: hold every stage right away.
          ctrl_mux   = 1'b1;
          state_next = MSTALL;
          saved_next = RUN;
        end else if (req_len != 2'd0) begin
          idex_write_en  = 1'b1;
          exmem_write_en = 1'b1;
          cnt_next       = req_len - 2'd1;
          if (req_len > 2'd1)
            state_next = DSTALL;
        end else begin
          pc_write_en    = 1'b1;
          ifid_write_en  = 1'b1;
          idex_write_en  = 1'b1;
          exmem_write_en = 1'b1;
          ctrl_mux       = 1'b1;
          ifid_flush     = branch_taken;
        end
      end
      DSTALL: begin
        // Remaining cycles of the window; ID inputs are not consulted.
        idex_write_en  = 1'b1;
        exmem_write_en = 1'b1;
        if (mem_busy) begin
          state_next = MSTALL;
          saved_next = DSTALL;
        end else begin
          cnt_next = cnt_reg - 2'd1;
          if (cnt_reg <= 2'd1)
            state_next = RUN;
        end
      end
      MSTALL: begin
        ctrl_mux = 1'b1;
        if (!mem_busy)
          state_next = saved_reg;
      end
      default: begin
        state_next = RUN;
      end
    endcase
    if (rst) begin
      pc_write_en    = 1'b0;
      ifid_write_en  = 1'b0;
      idex_write_en  = 1'b0;
      exmem_write_en = 1'b0;
      ctrl_mux       = 1'b0;
      ifid_flush     = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic        stall_inc;
  logic        mstall_inc;
  logic [15:0] stall_cycles_reg, mem_stall_cycles_reg, flush_count_reg;

  // Events counted: data-stall cycles (held window or single RUN stall),
  // memory-freeze cycles, and IF/ID flush pulses.
  always_comb begin
    stall_inc  = (state_reg == DSTALL) |
                 ((state_reg == RUN) & ~mem_busy & (req_len != 2'd0));
    mstall_inc = (state_reg == MSTALL);
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_reg     <= 16'd0;
      mem_stall_cycles_reg <= 16'd0;
      flush_count_reg      <= 16'd0;
    end else begin
      if (stall_inc && stall_cycles_reg != 16'hFFFF)
        stall_cycles_reg <= stall_cycles_reg + 16'd1;
      if (mstall_inc && mem_stall_cycles_reg != 16'hFFFF)
        mem_stall_cycles_reg <= mem_stall_cycles_reg + 16'd1;
      if (ifid_flush && flush_count_reg != 16'hFFFF)
        flush_count_reg <= flush_count_reg + 16'd1;
    end
  end

  assign stall_cycles     = stall_cycles_reg;
  assign mem_stall_cycles = mem_stall_cycles_reg;
  assign flush_count      = flush_count_reg;
`else
  assign stall_cycles     = 16'd0;
  assign mem_stall_cycles = 16'd0;
  assign flush_count      = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: table-driven single-cycle vectors
// followed by hand-written multi-cycle stall, freeze and reset sequences.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ifid_opcode, ifid_rs, ifid_rt, idex_rd, exmem_rd;
  logic        idex_regwrite, idex_memread, exmem_regwrite;
  logic [2:0]  idex_flag_en;
  logic        branch_taken, mem_busy;

  logic        pc_write_en, ifid_write_en, idex_write_en, exmem_write_en;
  logic        ctrl_mux, ifid_flush;
  logic [15:0] stall_cycles, mem_stall_cycles, flush_count;

  logic        nx_pc, nx_ifid, nx_idex, nx_exmem, nx_mux, nx_flush;
  logic [15:0] nx_stall, nx_mstall, nx_fcnt;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] RUNO   = 6'b111110;
  localparam logic [5:0] RUNF   = 6'b111111;
  localparam logic [5:0] STALL  = 6'b001100;
  localparam logic [5:0] FREEZE = 6'b000010;
  localparam logic [5:0] RSTO   = 6'b000000;

  logic [5:0] outs, nx_outs;
  assign outs    = {pc_write_en, ifid_write_en, idex_write_en, exmem_write_en, ctrl_mux, ifid_flush};
  assign nx_outs = {nx_pc, nx_ifid, nx_idex, nx_exmem, nx_mux, nx_flush};

  always #5 clk = ~clk;

  hazard_stall_ctrl u_dut (
    .clk(clk), .rst(rst),
    .ifid_opcode(ifid_opcode), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_rd(idex_rd), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .idex_flag_en(idex_flag_en), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .idex_write_en(idex_write_en), .exmem_write_en(exmem_write_en),
    .ctrl_mux(ctrl_mux), .ifid_flush(ifid_flush),
    .stall_cycles(stall_cycles), .mem_stall_cycles(mem_stall_cycles),
    .flush_count(flush_count)
  );

  hazard_stall_ctrl #(.ZERO_REG_EXCL(0)) u_dut_nx (
    .clk(clk), .rst(rst),
    .ifid_opcode(ifid_opcode), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_rd(idex_rd), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .idex_flag_en(idex_flag_en), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write_en(nx_pc), .ifid_write_en(nx_ifid),
    .idex_write_en(nx_idex), .exmem_write_en(nx_exmem),
    .ctrl_mux(nx_mux), .ifid_flush(nx_flush),
    .stall_cycles(nx_stall), .mem_stall_cycles(nx_mstall),
    .flush_count(nx_fcnt)
  );

  typedef struct {
    logic [3:0] opc, rs, rt, idex_rd;
    logic       idex_rw, idex_mr;
    logic [2:0] flag;
    logic [3:0] exmem_rd;
    logic       exmem_rw, bt;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: value %0h", name, act);
    end
  endtask

  task automatic clear_inputs();
    ifid_opcode = 4'd0; ifid_rs = 4'd1; ifid_rt = 4'd2;
    idex_rd = 4'd9; idex_regwrite = 1'b0; idex_memread = 1'b0;
    idex_flag_en = 3'd0; exmem_rd = 4'd9; exmem_regwrite = 1'b0;
    branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_br_dep();
    clear_inputs();
    ifid_opcode = 4'b1101; idex_regwrite = 1'b1; idex_rd = 4'd5; ifid_rs = 4'd5;
  endtask

  // Inputs are set just after a rising edge; sample at the falling edge,
  // then advance to just past the next rising edge.
  task automatic step_check(input string name, input logic [5:0] exp);
    @(negedge clk);
    check(name, {26'd0, outs}, {26'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] base_s, base_m;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] base_s, base_m;
    //                opc     rs  rt  idrd rw  mr  flag    exrd erw bt  exp
    vecs[0]  = '{4'b0000, 4'd1, 4'd2, 4'd9, 1'b0, 1'b0, 3'b000, 4'd9, 1'b0, 1'b0, RUNO};
    vecs[1]  = '{4'b0000, 4'd3, 4'd4, 4'd3, 1'b1, 1'b1, 3'b000, 4'd9, 1'b0, 1'b0, STALL};
    vecs[2]  = '{4'b0000, 4'd1, 4'd3, 4'd3, 1'b1, 1'b1, 3'b000, 4'd9, 1'b0, 1'b0, STALL};
    vecs[3]  = '{4'b0000, 4'd1, 4'd0, 4'd0, 1'b1, 1'b1, 3'b000, 4'd9, 1'b0, 1'b0, RUNO};
    vecs[4]  = '{4'b0000, 4'd3, 4'd4, 4'd3, 1'b1, 1'b0, 3'b000, 4'd9, 1'b0, 1'b0, RUNO};
    vecs[5]  = '{4'b1100, 4'd1, 4'd2, 4'd9, 1'b0, 1'b0, 3'b010, 4'd9, 1'b0, 1'b0, STALL};
    vecs[6]  = '{4'b0000, 4'd1, 4'd2, 4'd9, 1'b0, 1'b0, 3'b111, 4'd9, 1'b0, 1'b0, RUNO};
    vecs[7]  = '{4'b1101, 4'd7, 4'd2, 4'd9, 1'b0, 1'b0, 3'b000, 4'd7, 1'b1, 1'b0, STALL};
    vecs[8]  = '{4'b1101, 4'd0, 4'd2, 4'd9, 1'b0, 1'b0, 3'b000, 4'd0, 1'b1, 1'b0, RUNO};
    vecs[9]  = '{4'b0000, 4'd1, 4'd2, 4'd9, 1'b0, 1'b0, 3'b000, 4'd9, 1'b0, 1'b1, RUNF};
    vecs[10] = '{4'b1100, 4'd5, 4'd2, 4'd5, 1'b1, 1'b0, 3'b000, 4'd9, 1'b0, 1'b0, RUNO};
    vecs[11] = '{4'b0000, 4'd6, 4'd2, 4'd6, 1'b1, 1'b1, 3'b000, 4'd9, 1'b0, 1'b1, STALL};
    vecs[12] = '{4'b1101, 4'd4, 4'd2, 4'd9, 1'b0, 1'b0, 3'b000, 4'd4, 1'b0, 1'b0, RUNO};

    // Reset state
    clear_inputs();
    rst = 1'b1;
    #3;
    check("reset_outs", {26'd0, outs}, {26'd0, RSTO});
    check("reset_stall_cnt", {16'd0, stall_cycles}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven single-cycle vectors (all start and end in RUN)
    for (int i = 0; i < 13; i++) begin
      ifid_opcode = vecs[i].opc; ifid_rs = vecs[i].rs; ifid_rt = vecs[i].rt;
      idex_rd = vecs[i].idex_rd; idex_regwrite = vecs[i].idex_rw;
      idex_memread = vecs[i].idex_mr; idex_flag_en = vecs[i].flag;
      exmem_rd = vecs[i].exmem_rd; exmem_regwrite = vecs[i].exmem_rw;
      branch_taken = vecs[i].bt; mem_busy = 1'b0;
      step_check($sformatf("vec%0d", i), vecs[i].exp);
    end
`ifdef HAZARD_PERF_EN
    check("vec_stall_cnt", {16'd0, stall_cycles}, 32'd5);
    check("vec_flush_cnt", {16'd0, flush_count}, 32'd1);
`endif

    // BR with ALU producer in EX: two-cycle window, hazard not re-sampled,
    // branch_taken ignored while stalled.
    base_s = stall_cycles;
    set_br_dep();
    step_check("br_stall_c0", STALL);
    clear_inputs();
    branch_taken = 1'b1;
    step_check("br_stall_c1_noflush", STALL);
    clear_inputs();
    step_check("br_stall_done", RUNO);
`ifdef HAZARD_PERF_EN
    check("br_stall_cnt", {16'd0, stall_cycles - base_s}, 32'd2);
`endif

    // Memory freeze arriving on the second cycle of a BR stall
    base_s = stall_cycles;
    base_m = mem_stall_cycles;
    set_br_dep();
    step_check("mf_c0", STALL);
    clear_inputs();
    mem_busy = 1'b1;
    step_check("mf_c1", STALL);
    step_check("mf_c2", FREEZE);
    step_check("mf_c3", FREEZE);
    mem_busy = 1'b0;
    step_check("mf_c4", FREEZE);
    step_check("mf_c5_rest", STALL);
    step_check("mf_c6_run", RUNO);
`ifdef HAZARD_PERF_EN
    check("mf_mstall_cnt", {16'd0, mem_stall_cycles - base_m}, 32'd3);
    check("mf_stall_cnt", {16'd0, stall_cycles - base_s}, 32'd3);
`endif

    // R0 exclusion on vs off
    clear_inputs();
    idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 4'd0; ifid_rt = 4'd0;
    @(negedge clk);
    check("r0_excl_on", {26'd0, outs}, {26'd0, RUNO});
    check("r0_excl_off", {26'd0, nx_outs}, {26'd0, STALL});
    @(posedge clk);
    #1;

    // Asynchronous reset while in DSTALL
    set_br_dep();
    step_check("rst_pre_c0", STALL);
    clear_inputs();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_stall", {26'd0, outs}, {26'd0, RSTO});
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_release_run", {26'd0, outs}, {26'd0, RUNO});
    @(posedge clk);
    #1;

`ifndef HAZARD_PERF_EN
    check("perf_tied_zero", {stall_cycles, mem_stall_cycles | flush_count}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
